// File: rtl/pcounter_cfg_arb.sv
// pcounter_cfg_arb: round-robin arbiter/sequencer for the pcounter config bus.
//
// Each of NUM_REQ requesters offers one transaction via valid/ready. In IDLE
// the first valid requester at or after rr_ptr (with wrap) is granted, its
// fields are loaded straight into the registered cfg outputs, and the FSM
// spends one ISSUE cycle (cfg_enable_sig high) followed by GAP_CYCLES idle
// cycles before it can accept again.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       per-requester valid
//   req_rd_wr       per-requester direction (1 = write)
//   req_addr        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata       packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_lock        (PCOUNTER_CFG_ARB_LOCK_EN only) per-requester lock request
//   req_ready       one-hot grant, combinational, only in IDLE
//   cfg_*_sig       registered cfg bus outputs
//   busy            high whenever the FSM is not IDLE
//
// Optional feature macro: PCOUNTER_CFG_ARB_LOCK_EN (bus locking by a requester).
module pcounter_cfg_arb #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rd_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef PCOUNTER_CFG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cfg_enable_sig,
    output logic                      cfg_rd_wr_sig,
    output logic [ADDR_W-1:0]         cfg_addr_sig,
    output logic [DATA_W-1:0]         cfg_wdata_sig,
    output logic                      busy
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]          gap_q, gap_d;
    logic                cfg_enable_q, cfg_enable_d;
    logic                cfg_rd_wr_q, cfg_rd_wr_d;
    logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
    logic [DATA_W-1:0]   cfg_wdata_q, cfg_wdata_d;

    logic [NUM_REQ-1:0]  elig;
    logic                found;
    logic [PtrW-1:0]     winner;
    logic [PtrW-1:0]     winner_nxt;

`ifdef PCOUNTER_CFG_ARB_LOCK_EN
    logic                lock_q, lock_d;
    logic [PtrW-1:0]     owner_q, owner_d;
`endif

    // Eligible set: everyone who is valid, or only the lock owner while locked.
    always_comb begin
        elig = req_valid;
`ifdef PCOUNTER_CFG_ARB_LOCK_EN
        if (lock_q) begin
            elig          = '0;
            elig[owner_q] = req_valid[owner_q];
        end
`endif
    end

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            logic [PtrW-1:0] idx;
            idx = PtrW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        winner_nxt = (winner == PtrW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gap_d        = gap_q;
        cfg_enable_d = 1'b0;
        cfg_rd_wr_d  = cfg_rd_wr_q;
        cfg_addr_d   = cfg_addr_q;
        cfg_wdata_d  = cfg_wdata_q;
        req_ready    = '0;
`ifdef PCOUNTER_CFG_ARB_LOCK_EN
        lock_d       = lock_q;
        owner_d      = owner_q;
`endif
        case (state_q)
            StIdle: begin
                // found implies the winner is valid, so ready always transfers.
                if (found && !rst) begin
                    req_ready[winner] = 1'b1;
                    state_d           = StIssue;
                    cfg_enable_d      = 1'b1;
                    cfg_rd_wr_d       = req_rd_wr[winner];
                    cfg_addr_d        = req_addr[winner*ADDR_W +: ADDR_W];
                    cfg_wdata_d       = req_rd_wr[winner] ?
                                        req_wdata[winner*DATA_W +: DATA_W] : '0;
`ifdef PCOUNTER_CFG_ARB_LOCK_EN
                    if (req_lock[winner]) begin
                        lock_d  = 1'b1;
                        owner_d = winner;
                    end else begin
                        lock_d   = 1'b0;
                        rr_ptr_d = winner_nxt;
                    end
`else
                    rr_ptr_d = winner_nxt;
`endif
                end
            end
            StIssue: begin
                if (GAP_CYCLES > 0) begin
                    state_d = StGap;
                    gap_d   = 4'(GAP_CYCLES - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            gap_q        <= '0;
            cfg_enable_q <= 1'b0;
            cfg_rd_wr_q  <= 1'b0;
            cfg_addr_q   <= '0;
            cfg_wdata_q  <= '0;
`ifdef PCOUNTER_CFG_ARB_LOCK_EN
            lock_q       <= 1'b0;
            owner_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gap_q        <= gap_d;
            cfg_enable_q <= cfg_enable_d;
            cfg_rd_wr_q  <= cfg_rd_wr_d;
            cfg_addr_q   <= cfg_addr_d;
            cfg_wdata_q  <= cfg_wdata_d;
`ifdef PCOUNTER_CFG_ARB_LOCK_EN
            lock_q       <= lock_d;
            owner_q      <= owner_d;
`endif
        end
    end

    assign cfg_enable_sig = cfg_enable_q;
    assign cfg_rd_wr_sig  = cfg_rd_wr_q;
    assign cfg_addr_sig   = cfg_addr_q;
    assign cfg_wdata_sig  = cfg_wdata_q;
    assign busy           = (state_q != StIdle);

endmodule
